counter_bank_cc: RTL and testbench
==================================

Name: counter_bank_cc

Overview:
- Parametrised multi-channel capture/compare counter bank.
- Each channel has a prescaler, up/down period counter, compare output and capture FIFO.
- A channel can optionally clock from the wrap event of the channel below it (cascade).
- Sits beside the per-channel counter array and serves as its generalised, single-clock-domain successor for timer/PWM/capture use.

Parameters:
- NUM_CH, 4, number of channels (1..16).
- CNT_WIDTH, 32, counter/period/compare width in bits.
- PRE_WIDTH, 8, prescaler width.
- CAP_DEPTH, 4, capture FIFO entries per channel (power of two, >=2).

Ports:
- i_clk  in  1  clock; single domain for the whole block.
- i_rst  in  1  reset, synchronous, active-high.
- i_enable  in  NUM_CH  per-channel enable.
- i_global_start  in  1  pulse; starts every enabled channel.
- i_global_stop  in  1  pulse; stops all channels.
- i_cascade  in  NUM_CH  1 = channel i ticks on wrap of channel i-1; bit0 ignored.
- i_dir  in  NUM_CH  0 = up, 1 = down.
- i_prescale  in  NUM_CH*PRE_WIDTH  tick every (n+1) clocks.
- i_period  in  NUM_CH*CNT_WIDTH  wrap value.
- i_compare  in  NUM_CH*CNT_WIDTH  compare value.
- i_cap_din  in  NUM_CH  capture inputs, already synchronous to i_clk.
- i_cap_edge  in  NUM_CH*2  00 off, 01 rise, 10 fall, 11 both.
- i_cap_rd  in  NUM_CH  FIFO pop.
- i_ovf_clr  in  NUM_CH  clears sticky overflow.
- o_count  out  NUM_CH*CNT_WIDTH  live counter value.
- o_cmp_out  out  NUM_CH  compare output.
- o_wrap  out  NUM_CH  one-cycle wrap pulse.
- o_cap_data  out  NUM_CH*CNT_WIDTH  FIFO head (show-ahead).
- o_cap_valid  out  NUM_CH  FIFO not empty.
- o_cap_overflow  out  NUM_CH  sticky capture-drop flag.
- o_int  out  NUM_CH*2  per channel: bit0 wrap, bit1 capture pushed; one-cycle pulses.

Behaviour:
- Reset:
  - all outputs 0, FIFOs empty, prescalers 0, edge-detect registers 0.
  - All channels in STOP; i_rst wins over every other input in the same cycle.
- Per-channel FSM STOP/RUN:
  - STOP->RUN on i_global_start while i_enable=1.
  - RUN->STOP on i_global_stop or i_enable=0.
  - Start and stop in the same cycle: stop wins.
  - The counter holds its value in STOP; it is not cleared.
  - Entering RUN clears the prescaler only.
- Tick (non-cascade):
  - In RUN, prescaler counts 0..i_prescale.
  - Tick asserted in the cycle prescaler == i_prescale; prescaler returns to 0 that cycle.
  - i_prescale=0 gives a tick every clock.
- Tick (cascade, i>0, i_cascade[i]=1): tick = registered o_wrap[i-1], i.e. one clock lag; own prescaler ignored. Channel must itself be in RUN.
- Count:
  - Up: on tick, count==period -> 0 with wrap, else +1.
  - Down: on tick, count==0 -> period with wrap, else -1.
  - Count > period (period lowered at runtime): up mode still increments until its modulo-2^CNT_WIDTH rollover passes period; down mode counts down normally.
  - Period 0: wraps every tick.
- o_wrap, o_int bit0: high the cycle after the wrapping tick.
- o_cmp_out:
  - registered: next count < compare in up mode, next count >= compare in down mode.
  - Updates in the same edge as o_count.
  - compare > period in up mode -> constant 1.
- Capture:
  - Edge detected by comparing i_cap_din against its one-cycle-delayed copy.
  - On selected edge, o_count (pre-update value of that cycle) is pushed.
  - Capture is active in STOP too.
  - o_int bit1 pulses the cycle after the push.
- FIFO:
  - Show-ahead: o_cap_data valid in the cycle after the push.
  - Pop when empty is ignored.
  - Push when full without a pop: data dropped, o_cap_overflow set, FIFO unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow.
  - i_ovf_clr and a new overflow in the same cycle: flag stays set.
- Latency summary:
  - config inputs take effect at the next tick.
  - wrap/int pulses are 1 cycle after the event.

Optional Feature:
COUNTER_BANK_CC_ONESHOT_EN
- Defined: adds input i_oneshot (NUM_CH). A channel with the bit set goes RUN->STOP on its wrap tick. The count holds the post-wrap value (0 up / period down); o_wrap still pulses.
- Undefined: port absent; channels run free until stopped.

Test Plan:
- Ch0 up, prescale=0, period=3, compare=2, start -> o_count 0,1,2,3,0; o_cmp_out 1,1,0,0,1; o_wrap pulse 1 cycle after the 3->0 transition, then every 4 clocks.
- Ch1 down, prescale=2, period=5 -> counts 5..0 change every 3 clocks; wrap 0->5 after 18 clocks.
- Ch1 cascade, ch0 period=1, ch1 up period=2 -> ch1 increments once per 2 ch0 ticks, 1 clock after each o_wrap[0]; ch1 wraps every 6 clocks.
- Ch2 edge=11, 5 toggles with no pops, CAP_DEPTH=4 -> 4 entries holding the captured counts, 5th dropped, o_cap_overflow=1. Then pop+toggle in the same cycle -> count stays 4, no new overflow. i_ovf_clr -> flag 0.
- Global start and stop asserted together -> all channels stay STOP. Then i_rst mid-count (count=7) -> all outputs 0 next cycle.
- ONESHOT_EN: i_oneshot[0]=1, period=2 -> counts 0,1,2,0 then STOP, held at 0; one wrap pulse only.

Source files
------------

// File: rtl/counter_bank_cc.sv
// counter_bank_cc: parametrised multi-channel capture/compare counter bank.
// Each channel has a prescaler, an up/down period counter, a registered
// compare output and an edge-triggered capture FIFO (show-ahead). Channel i
// can instead tick on the wrap pulse of channel i-1 (cascade).
// Optional feature macro: COUNTER_BANK_CC_ONESHOT_EN adds input i_oneshot;
// a channel with its bit set drops back to STOP on its own wrap tick.
module counter_bank_cc #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32,
    parameter int PRE_WIDTH = 8,
    parameter int CAP_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_CH-1:0]           i_enable,
    input  logic                        i_global_start,
    input  logic                        i_global_stop,
    input  logic [NUM_CH-1:0]           i_cascade,
    input  logic [NUM_CH-1:0]           i_dir,
    input  logic [NUM_CH*PRE_WIDTH-1:0] i_prescale,
    input  logic [NUM_CH*CNT_WIDTH-1:0] i_period,
    input  logic [NUM_CH*CNT_WIDTH-1:0] i_compare,
    input  logic [NUM_CH-1:0]           i_cap_din,
    input  logic [NUM_CH*2-1:0]         i_cap_edge,
    input  logic [NUM_CH-1:0]           i_cap_rd,
    input  logic [NUM_CH-1:0]           i_ovf_clr,
`ifdef COUNTER_BANK_CC_ONESHOT_EN
    input  logic [NUM_CH-1:0]           i_oneshot,
`endif
    output logic [NUM_CH*CNT_WIDTH-1:0] o_count,
    output logic [NUM_CH-1:0]           o_cmp_out,
    output logic [NUM_CH-1:0]           o_wrap,
    output logic [NUM_CH*CNT_WIDTH-1:0] o_cap_data,
    output logic [NUM_CH-1:0]           o_cap_valid,
    output logic [NUM_CH-1:0]           o_cap_overflow,
    output logic [NUM_CH*2-1:0]         o_int
);

    localparam int PTR_W = $clog2(CAP_DEPTH);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PRE_WIDTH-1:0] PRE_ONE   = PRE_WIDTH'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]       FILL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]       FILL_FULL = (PTR_W + 1)'(CAP_DEPTH);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_t;

    // Wrap pulses of all channels, gathered so a channel can see its neighbour.
    logic [NUM_CH-1:0] wrap_vec;
    assign o_wrap = wrap_vec;

    // Channel 0 has no lower neighbour, so its cascade bit has no meaning.
    logic unused_cascade0;
    assign unused_cascade0 = i_cascade[0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_t              state_q, state_d;
        logic [PRE_WIDTH-1:0]   presc_q;
        logic [CNT_WIDTH-1:0]   count_q, count_d;
        logic                   cmp_q, wrap_q, int_cap_q, ovf_q;
        logic                   tick, wrap_tick;
        logic                   casc_en, casc_tick, oneshot;
        logic [PRE_WIDTH-1:0]   prescale;
        logic [CNT_WIDTH-1:0]   period, compare;
        logic                   cap_prev_q, rise, fall, push_req;
        logic                   pop_ok, push_ok, fifo_full, fifo_empty;
        logic [1:0]             edge_sel;
        logic [CNT_WIDTH-1:0]   fifo_mem [CAP_DEPTH];
        logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
        logic [PTR_W:0]         fill_q;

        assign prescale = i_prescale[g*PRE_WIDTH +: PRE_WIDTH];
        assign period   = i_period[g*CNT_WIDTH +: CNT_WIDTH];
        assign compare  = i_compare[g*CNT_WIDTH +: CNT_WIDTH];
        assign edge_sel = i_cap_edge[g*2 +: 2];

        if (g == 0) begin : g_no_casc
            assign casc_en   = 1'b0;
            assign casc_tick = 1'b0;
        end else begin : g_casc
            assign casc_en   = i_cascade[g];
            assign casc_tick = wrap_vec[g-1];
        end

`ifdef COUNTER_BANK_CC_ONESHOT_EN
        assign oneshot = i_oneshot[g];
`else
        assign oneshot = 1'b0;
`endif

        // Run/stop state register.
        always_ff @(posedge i_clk) begin
            if (i_rst) state_q <= ST_STOP;
            else       state_q <= state_d;
        end

        // Tick selection, next count with wrap detection, and next run state (stop beats start).
        always_comb begin
            state_d   = state_q;
            tick      = 1'b0;
            wrap_tick = 1'b0;
            count_d   = count_q;
            if (state_q == ST_RUN) begin
                tick = casc_en ? casc_tick : (presc_q == prescale);
            end
            if (tick) begin
                if (i_dir[g]) begin
                    if (count_q == '0) begin
                        count_d   = period;
                        wrap_tick = 1'b1;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end else begin
                    if (count_q == period) begin
                        count_d   = '0;
                        wrap_tick = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            case (state_q)
                ST_STOP: begin
                    if (i_global_start && i_enable[g] && !i_global_stop) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (i_global_stop || !i_enable[g] || (oneshot && wrap_tick)) state_d = ST_STOP;
                end
                default: state_d = ST_STOP;
            endcase
        end

        // Prescaler runs only in RUN and sits at zero otherwise, so entering RUN starts it fresh.
        always_ff @(posedge i_clk) begin
            if (i_rst || state_q != ST_RUN) presc_q <= '0;
            else if (presc_q == prescale)   presc_q <= '0;
            else                            presc_q <= presc_q + PRE_ONE;
        end

        // Counter, compare output (from the next count so both change together) and wrap pulse.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                count_q <= '0;
                cmp_q   <= 1'b0;
                wrap_q  <= 1'b0;
            end else begin
                count_q <= count_d;
                cmp_q   <= i_dir[g] ? (count_d >= compare) : (count_d < compare);
                wrap_q  <= wrap_tick;
            end
        end

        assign rise       = i_cap_din[g] & ~cap_prev_q;
        assign fall       = ~i_cap_din[g] & cap_prev_q;
        assign push_req   = (edge_sel[0] & rise) | (edge_sel[1] & fall);
        assign fifo_full  = (fill_q == FILL_FULL);
        assign fifo_empty = (fill_q == '0);
        assign pop_ok     = i_cap_rd[g] & ~fifo_empty;
        assign push_ok    = push_req & (~fifo_full | pop_ok);

        // Capture edge history, FIFO pointers/fill, capture interrupt and sticky overflow.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                cap_prev_q <= 1'b0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                fill_q     <= '0;
                int_cap_q  <= 1'b0;
                ovf_q      <= 1'b0;
            end else begin
                cap_prev_q <= i_cap_din[g];
                int_cap_q  <= push_ok;
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                case ({push_ok, pop_ok})
                    2'b10:   fill_q <= fill_q + FILL_ONE;
                    2'b01:   fill_q <= fill_q - FILL_ONE;
                    default: fill_q <= fill_q;
                endcase
                if (push_req && fifo_full && !pop_ok) ovf_q <= 1'b1;
                else if (i_ovf_clr[g])                ovf_q <= 1'b0;
            end
        end

        // Capture storage holds the live count seen in the cycle of the edge.
        always_ff @(posedge i_clk) begin
            if (push_ok) fifo_mem[wr_ptr_q] <= count_q;
        end

        assign wrap_vec[g]                          = wrap_q;
        assign o_count[g*CNT_WIDTH +: CNT_WIDTH]    = count_q;
        assign o_cmp_out[g]                         = cmp_q;
        assign o_cap_data[g*CNT_WIDTH +: CNT_WIDTH] = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
        assign o_cap_valid[g]                       = ~fifo_empty;
        assign o_cap_overflow[g]                    = ovf_q;
        assign o_int[g*2]                           = wrap_q;
        assign o_int[g*2+1]                         = int_cap_q;
    end

endmodule

// File: tb/tb_counter_bank_cc.sv
// tb_counter_bank_cc: directed scoreboard bench for counter_bank_cc.
// Stimulus pushes expected values tagged with the cycle they must appear;
// a negedge monitor pops and compares them, and separately matches every
// o_wrap pulse against a queue of predicted wraps.
module tb_counter_bank_cc;

    localparam int NUM_CH    = 4;
    localparam int CNT_WIDTH = 32;
    localparam int PRE_WIDTH = 8;
    localparam int CAP_DEPTH = 4;

    localparam int K_COUNT = 0;
    localparam int K_CMP   = 1;
    localparam int K_CAPV  = 2;
    localparam int K_CAPD  = 3;
    localparam int K_OVF   = 4;
    localparam int K_INT1  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        int          ch;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        int cyc;
        int ch;
    } wexp_t;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_CH-1:0]           enable = '0;
    logic                        start = 1'b0;
    logic                        stop = 1'b0;
    logic [NUM_CH-1:0]           cascade = '0;
    logic [NUM_CH-1:0]           dir = '0;
    logic [NUM_CH*PRE_WIDTH-1:0] prescale = '0;
    logic [NUM_CH*CNT_WIDTH-1:0] period = '0;
    logic [NUM_CH*CNT_WIDTH-1:0] compare = '0;
    logic [NUM_CH-1:0]           cap_din = '0;
    logic [NUM_CH*2-1:0]         cap_edge = '0;
    logic [NUM_CH-1:0]           cap_rd = '0;
    logic [NUM_CH-1:0]           ovf_clr = '0;
`ifdef COUNTER_BANK_CC_ONESHOT_EN
    logic [NUM_CH-1:0]           oneshot = '0;
`endif
    logic [NUM_CH*CNT_WIDTH-1:0] o_count;
    logic [NUM_CH-1:0]           o_cmp_out;
    logic [NUM_CH-1:0]           o_wrap;
    logic [NUM_CH*CNT_WIDTH-1:0] o_cap_data;
    logic [NUM_CH-1:0]           o_cap_valid;
    logic [NUM_CH-1:0]           o_cap_overflow;
    logic [NUM_CH*2-1:0]         o_int;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    base;
    exp_t  exp_q[$];
    wexp_t wexp_q[$];
    string kind_name [6] = '{"count", "cmp_out", "cap_valid", "cap_data", "cap_overflow", "int_cap"};

    counter_bank_cc #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .PRE_WIDTH(PRE_WIDTH), .CAP_DEPTH(CAP_DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_global_start (start),
        .i_global_stop  (stop),
        .i_cascade      (cascade),
        .i_dir          (dir),
        .i_prescale     (prescale),
        .i_period       (period),
        .i_compare      (compare),
        .i_cap_din      (cap_din),
        .i_cap_edge     (cap_edge),
        .i_cap_rd       (cap_rd),
        .i_ovf_clr      (ovf_clr),
`ifdef COUNTER_BANK_CC_ONESHOT_EN
        .i_oneshot      (oneshot),
`endif
        .o_count        (o_count),
        .o_cmp_out      (o_cmp_out),
        .o_wrap         (o_wrap),
        .o_cap_data     (o_cap_data),
        .o_cap_valid    (o_cap_valid),
        .o_cap_overflow (o_cap_overflow),
        .o_int          (o_int)
    );

    always #5 clk = ~clk;

    // Cycle stamp: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] probe(int kind, int ch);
        case (kind)
            K_COUNT: return o_count[ch*CNT_WIDTH +: CNT_WIDTH];
            K_CMP:   return 32'(o_cmp_out[ch]);
            K_CAPV:  return 32'(o_cap_valid[ch]);
            K_CAPD:  return o_cap_data[ch*CNT_WIDTH +: CNT_WIDTH];
            K_OVF:   return 32'(o_cap_overflow[ch]);
            K_INT1:  return 32'(o_int[ch*2+1]);
            default: return 32'hdeadbeef;
        endcase
    endfunction

    task automatic check_output(input exp_t e);
        logic [31:0] got;
        got = probe(e.kind, e.ch);
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("[TB] FAIL %s ch%0d cycle %0d: got %0d expected %0d",
                     kind_name[e.kind], e.ch, e.cyc, got, e.val);
        end
    endtask

    // Monitor: compare every scheduled expectation and every wrap pulse.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                check_output(exp_q[i]);
                exp_q.delete(i);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            int hit;
            hit = -1;
            for (int i = 0; i < wexp_q.size(); i++) begin
                if (wexp_q[i].cyc == cyc && wexp_q[i].ch == c) hit = i;
            end
            if (hit >= 0 || o_wrap[c] === 1'b1) begin
                checks++;
                if (hit < 0) begin
                    errors++;
                    $display("[TB] FAIL wrap ch%0d cycle %0d: got pulse expected none", c, cyc);
                end else if (o_wrap[c] !== 1'b1 || o_int[c*2] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL wrap ch%0d cycle %0d: got wrap=%b int0=%b expected 1/1",
                             c, cyc, o_wrap[c], o_int[c*2]);
                end
                if (hit >= 0) wexp_q.delete(hit);
            end
        end
    end

    task automatic apply_stimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int kind, input int ch, input logic [31:0] val, input int at);
        exp_t e;
        e.cyc = at; e.kind = kind; e.ch = ch; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic expect_wrap(input int ch, input int at);
        wexp_t w;
        w.cyc = at; w.ch = ch;
        wexp_q.push_back(w);
    endtask

    task automatic set_ch(input int ch, input logic d, input int pre, input int per, input int cmp);
        dir[ch]                               = d;
        prescale[ch*PRE_WIDTH +: PRE_WIDTH]   = PRE_WIDTH'(pre);
        period[ch*CNT_WIDTH +: CNT_WIDTH]     = CNT_WIDTH'(per);
        compare[ch*CNT_WIDTH +: CNT_WIDTH]    = CNT_WIDTH'(cmp);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = '0; start = 1'b0; stop = 1'b0; cascade = '0; dir = '0;
        prescale = '0; period = '0; compare = '0; cap_din = '0; cap_edge = '0;
        cap_rd = '0; ovf_clr = '0;
`ifdef COUNTER_BANK_CC_ONESHOT_EN
        oneshot = '0;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            expect_at(K_COUNT, c, 0, cyc + 1);
            expect_at(K_CMP,   c, 0, cyc + 1);
            expect_at(K_CAPV,  c, 0, cyc + 1);
            expect_at(K_OVF,   c, 0, cyc + 1);
        end
        apply_stimulus(2);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        apply_stimulus(1);
        do_reset();

        // Up count, prescale 0, period 3; ch3 has compare above period.
        $display("[TB] up count / compare");
        set_ch(0, 1'b0, 0, 3, 2);
        set_ch(3, 1'b0, 0, 3, 5);
        enable = 4'b1001; start = 1'b1;
        base = cyc;
        expect_at(K_COUNT, 0, 0, base + 1); expect_at(K_CMP, 0, 1, base + 1);
        expect_at(K_COUNT, 0, 1, base + 2); expect_at(K_CMP, 0, 1, base + 2);
        expect_at(K_COUNT, 0, 2, base + 3); expect_at(K_CMP, 0, 0, base + 3);
        expect_at(K_COUNT, 0, 3, base + 4); expect_at(K_CMP, 0, 0, base + 4);
        expect_at(K_COUNT, 0, 0, base + 5); expect_at(K_CMP, 0, 1, base + 5);
        expect_at(K_CMP, 3, 1, base + 4);   expect_at(K_CMP, 3, 1, base + 5);
        for (int w = 5; w <= 13; w += 4) begin
            expect_wrap(0, base + w);
            expect_wrap(3, base + w);
        end
        expect_at(K_COUNT, 0, 1, base + 14);
        expect_at(K_COUNT, 0, 1, base + 16);
        expect_at(K_COUNT, 3, 1, base + 16);
        apply_stimulus(1);
        start = 1'b0;
        apply_stimulus(12);
        stop = 1'b1;
        apply_stimulus(1);
        stop = 1'b0;
        apply_stimulus(3);
        do_reset();

        // Down count on ch1, prescale 2, period 5, compare 3.
        $display("[TB] down count with prescaler");
        set_ch(1, 1'b1, 2, 5, 3);
        enable = 4'b0010; start = 1'b1;
        base = cyc;
        expect_at(K_COUNT, 1, 0, base + 1);  expect_at(K_CMP, 1, 0, base + 1);
        expect_at(K_COUNT, 1, 5, base + 4);  expect_at(K_CMP, 1, 1, base + 4);
        expect_at(K_COUNT, 1, 5, base + 6);
        expect_at(K_COUNT, 1, 4, base + 7);
        expect_at(K_COUNT, 1, 3, base + 10); expect_at(K_CMP, 1, 1, base + 10);
        expect_at(K_COUNT, 1, 2, base + 13); expect_at(K_CMP, 1, 0, base + 13);
        expect_at(K_COUNT, 1, 1, base + 16);
        expect_at(K_COUNT, 1, 0, base + 19);
        expect_at(K_COUNT, 1, 5, base + 22);
        expect_wrap(1, base + 4);
        expect_wrap(1, base + 22);
        apply_stimulus(1);
        start = 1'b0;
        apply_stimulus(22);
        do_reset();

        // Cascade: ch1 ticks on ch0 wrap, own prescaler ignored.
        $display("[TB] cascade");
        set_ch(0, 1'b0, 0, 1, 0);
        set_ch(1, 1'b0, 7, 2, 0);
        cascade = 4'b0010; enable = 4'b0011; start = 1'b1;
        base = cyc;
        expect_at(K_COUNT, 0, 1, base + 2);
        expect_at(K_COUNT, 0, 0, base + 3);
        expect_at(K_COUNT, 1, 0, base + 3);
        expect_at(K_COUNT, 1, 1, base + 4);
        expect_at(K_COUNT, 1, 1, base + 5);
        expect_at(K_COUNT, 1, 2, base + 6);
        expect_at(K_COUNT, 1, 0, base + 8);
        expect_at(K_COUNT, 1, 1, base + 10);
        for (int w = 3; w <= 15; w += 2) expect_wrap(0, base + w);
        expect_wrap(1, base + 8);
        expect_wrap(1, base + 14);
        apply_stimulus(1);
        start = 1'b0;
        apply_stimulus(14);
        do_reset();

        // Capture FIFO on ch2: fill, overflow, pop+push while full, drain, clear.
        $display("[TB] capture fifo");
        set_ch(2, 1'b0, 0, 100, 0);
        cap_edge = 8'b0011_0000;
        enable = 4'b0100; start = 1'b1;
        base = cyc;
        expect_at(K_CAPV, 2, 0, base + 2);
        expect_at(K_CAPV, 2, 1, base + 3);  expect_at(K_CAPD, 2, 1, base + 3);
        expect_at(K_INT1, 2, 1, base + 3);  expect_at(K_INT1, 2, 0, base + 4);
        expect_at(K_OVF,  2, 0, base + 10); expect_at(K_OVF,  2, 1, base + 11);
        expect_at(K_CAPD, 2, 1, base + 11);
        expect_at(K_CAPD, 2, 3, base + 13); expect_at(K_OVF,  2, 1, base + 13);
        expect_at(K_CAPD, 2, 5, base + 14);
        expect_at(K_CAPD, 2, 7, base + 15);
        expect_at(K_CAPD, 2, 11, base + 16); expect_at(K_CAPV, 2, 1, base + 16);
        expect_at(K_CAPV, 2, 0, base + 17);
        expect_at(K_CAPV, 2, 0, base + 18); expect_at(K_CAPD, 2, 0, base + 18);
        expect_at(K_OVF,  2, 0, base + 18);
        apply_stimulus(1);
        start = 1'b0;
        apply_stimulus(1);
        for (int t = 0; t < 5; t++) begin
            cap_din[2] = ~cap_din[2];
            apply_stimulus(2);
        end
        cap_din[2] = ~cap_din[2];
        cap_rd[2]  = 1'b1;
        apply_stimulus(5);
        ovf_clr[2] = 1'b1;
        apply_stimulus(1);
        ovf_clr[2] = 1'b0;
        cap_rd[2]  = 1'b0;
        apply_stimulus(1);
        do_reset();

        // Start+stop together, then reset mid-count with start asserted.
        $display("[TB] start/stop priority and reset");
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 1'b0, 0, 10, 10);
        enable = 4'b1111; start = 1'b1; stop = 1'b1;
        base = cyc;
        expect_at(K_COUNT, 0, 0, base + 3);
        expect_at(K_COUNT, 3, 0, base + 3);
        apply_stimulus(1);
        start = 1'b0; stop = 1'b0;
        apply_stimulus(3);
        start = 1'b1;
        base = cyc;
        expect_at(K_COUNT, 0, 7, base + 8); expect_at(K_CMP, 0, 1, base + 8);
        expect_at(K_COUNT, 2, 7, base + 8);
        for (int c = 0; c < NUM_CH; c++) expect_at(K_COUNT, c, 0, base + 9);
        expect_at(K_CMP, 0, 0, base + 9);
        expect_at(K_COUNT, 0, 0, base + 11);
        apply_stimulus(1);
        start = 1'b0;
        apply_stimulus(7);
        rst = 1'b1; start = 1'b1;
        apply_stimulus(1);
        rst = 1'b0; start = 1'b0;
        apply_stimulus(3);
        do_reset();

`ifdef COUNTER_BANK_CC_ONESHOT_EN
        // One-shot: single pass 0,1,2,0 then hold in STOP.
        $display("[TB] oneshot");
        set_ch(0, 1'b0, 0, 2, 0);
        oneshot = 4'b0001; enable = 4'b0001; start = 1'b1;
        base = cyc;
        expect_at(K_COUNT, 0, 0, base + 1);
        expect_at(K_COUNT, 0, 1, base + 2);
        expect_at(K_COUNT, 0, 2, base + 3);
        expect_at(K_COUNT, 0, 0, base + 4);
        expect_at(K_COUNT, 0, 0, base + 5);
        expect_at(K_COUNT, 0, 0, base + 7);
        expect_wrap(0, base + 4);
        apply_stimulus(1);
        start = 1'b0;
        apply_stimulus(7);
        do_reset();
`endif

        apply_stimulus(2);
        checks++;
        if (exp_q.size() != 0 || wexp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover expectations: got %0d/%0d pending expected 0/0",
                     exp_q.size(), wexp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
